// File: rtl/nmu_axis_pkg.sv
// Shared types, constants and byte-lane helpers for NMU AXI-Stream pipeline stages.
package nmu_axis_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PAD  = 2'd1,
        DROP = 2'd2
    } pad_state_e;

    localparam int MIN_ETH_FRAME_BYTES = 60;

    // Widest tkeep the helpers handle (1024-bit bus); callers zero-extend and slice.
    localparam int MAX_KEEP_W = 128;

    function automatic logic [15:0] popcount(input logic [MAX_KEEP_W-1:0] i_vec);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            cnt = cnt + 16'(i_vec[i]);
        end
        return cnt;
    endfunction

    function automatic logic [MAX_KEEP_W-1:0] bytes_to_mask(input logic [15:0] i_bytes);
        logic [MAX_KEEP_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = (16'(i) < i_bytes);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready register slice; loads whenever empty or being drained.
module axis_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload,
    input  logic                 i_ready
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    assign o_ready   = !r_valid || i_ready;
    assign o_valid   = r_valid;
    assign o_payload = r_payload;

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_payload <= i_payload;
            end
        end
    end

endmodule

// File: rtl/eth_frame_padder.sv
// Zero-pads short Ethernet frames to MIN_FRAME_BYTES; optional truncation to
// MAX_PACKET_LENGTH when ETH_FRAME_PADDER_TRUNCATE_EN is defined.
module eth_frame_padder
    import nmu_axis_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int AXIS_DEST_WIDTH   = 4,
    parameter int MIN_FRAME_BYTES   = MIN_ETH_FRAME_BYTES,
    parameter int MAX_PACKET_LENGTH = 1522
) (
    input  logic                                                   aclk,
    input  logic                                                   areset,
    input  logic [AXIS_BUS_WIDTH-1:0]                              axis_in_tdata,
    input  logic [((AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1)-1:0]     axis_in_tid,
    input  logic [((AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1)-1:0] axis_in_tdest,
    input  logic [AXIS_BUS_WIDTH/8-1:0]                            axis_in_tkeep,
    input  logic                                                   axis_in_tlast,
    input  logic                                                   axis_in_tvalid,
    output logic                                                   axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]                              axis_out_tdata,
    output logic [((AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1)-1:0]     axis_out_tid,
    output logic [((AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1)-1:0] axis_out_tdest,
    output logic [AXIS_BUS_WIDTH/8-1:0]                            axis_out_tkeep,
    output logic                                                   axis_out_tlast,
    output logic                                                   axis_out_tvalid,
    input  logic                                                   axis_out_tready,
    output logic                                                   pad_event,
    output logic                                                   trunc_event
);

    localparam int          NB     = AXIS_BUS_WIDTH / 8;
    localparam int          ID_W   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
    localparam int          DEST_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1;
    localparam int          PL_W   = AXIS_BUS_WIDTH + NB + 1 + ID_W + DEST_W;
    localparam logic [16:0] MIN17  = 17'(MIN_FRAME_BYTES);
    localparam logic [16:0] MAX17  = 17'(MAX_PACKET_LENGTH);
    localparam logic [16:0] NB17   = 17'(NB);
    localparam logic [15:0] NB16   = 16'(NB);

    pad_state_e r_state, w_state_nxt;
    logic [15:0] r_byte_cnt, w_byte_cnt_nxt;
    logic [ID_W-1:0] r_last_id, w_id;
    logic [DEST_W-1:0] r_last_dest, w_dest;
    logic r_pad_event, r_trunc_event, w_pad_evt, w_trunc_evt;
    logic w_slot_free, w_reg_valid, w_out_valid;
    logic [AXIS_BUS_WIDTH-1:0] w_data, w_data_kept;
    logic [NB-1:0] w_keep, w_fill_mask;
    logic w_last;
    logic [PL_W-1:0] w_out_payload;
    logic [15:0] w_beat_bytes, w_fill_bytes, w_sum_sat;
    logic [16:0] w_sum17, w_rem17;
    logic w_fill_last;
    logic [MAX_KEEP_W-1:0] w_fill_full;
    logic w_unused;

    assign w_beat_bytes = popcount(MAX_KEEP_W'(axis_in_tkeep));
    assign w_sum17      = {1'b0, r_byte_cnt} + {1'b0, w_beat_bytes};
    assign w_sum_sat    = w_sum17[16] ? 16'hFFFF : w_sum17[15:0];

    // Bytes still owed to reach the minimum; only meaningful while byte_cnt < MIN.
    assign w_rem17      = MIN17 - {1'b0, r_byte_cnt};
    assign w_fill_last  = (w_rem17 <= NB17);
    assign w_fill_bytes = w_fill_last ? w_rem17[15:0] : NB16;
    assign w_fill_full  = bytes_to_mask(w_fill_bytes);
    assign w_fill_mask  = w_fill_full[NB-1:0];

`ifdef ETH_FRAME_PADDER_TRUNCATE_EN
    logic [15:0]           w_trunc_bytes;
    logic [MAX_KEEP_W-1:0] w_trunc_full;
    logic [NB-1:0]         w_trunc_mask;
    logic                  w_trunc_hit;

    assign w_trunc_bytes = MAX17[15:0] - r_byte_cnt;
    assign w_trunc_full  = bytes_to_mask(w_trunc_bytes);
    assign w_trunc_mask  = w_trunc_full[NB-1:0];
    assign w_trunc_hit   = (w_sum17 > MAX17);
    assign w_unused      = &{1'b0, w_fill_full[MAX_KEEP_W-1:NB], w_trunc_full[MAX_KEEP_W-1:NB]};
`else
    assign w_unused      = &{1'b0, w_fill_full[MAX_KEEP_W-1:NB], MAX17};
`endif

    // Lanes outside the input tkeep become zero when a short beat is widened.
    always_comb begin
        w_data_kept = '0;
        for (int i = 0; i < NB; i++) begin
            if (axis_in_tkeep[i]) begin
                w_data_kept[i*8 +: 8] = axis_in_tdata[i*8 +: 8];
            end
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        axis_in_tready = 1'b0;
        w_reg_valid    = 1'b0;
        w_data         = axis_in_tdata;
        w_keep         = axis_in_tkeep;
        w_last         = axis_in_tlast;
        w_id           = axis_in_tid;
        w_dest         = axis_in_tdest;
        w_pad_evt      = 1'b0;
        w_trunc_evt    = 1'b0;
        case (r_state)
            PASS: begin
                axis_in_tready = w_slot_free;
                w_reg_valid    = axis_in_tvalid;
                if (axis_in_tvalid && w_slot_free) begin
`ifdef ETH_FRAME_PADDER_TRUNCATE_EN
                    if (w_trunc_hit) begin
                        w_keep         = w_trunc_mask;
                        w_last         = 1'b1;
                        w_trunc_evt    = 1'b1;
                        w_byte_cnt_nxt = '0;
                        if (!axis_in_tlast) begin
                            w_state_nxt = DROP;
                        end
                    end else
`endif
                    if (axis_in_tlast && (w_sum17 < MIN17)) begin
                        w_data    = w_data_kept;
                        w_keep    = w_fill_mask;
                        w_last    = w_fill_last;
                        w_pad_evt = 1'b1;
                        if (w_fill_last) begin
                            w_byte_cnt_nxt = '0;
                        end else begin
                            w_byte_cnt_nxt = r_byte_cnt + w_fill_bytes;
                            w_state_nxt    = PAD;
                        end
                    end else begin
                        w_byte_cnt_nxt = axis_in_tlast ? '0 : w_sum_sat;
                    end
                end
            end
            PAD: begin
                w_reg_valid = 1'b1;
                w_data      = '0;
                w_keep      = w_fill_mask;
                w_last      = w_fill_last;
                w_id        = r_last_id;
                w_dest      = r_last_dest;
                if (w_slot_free) begin
                    if (w_fill_last) begin
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = PASS;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + NB16;
                    end
                end
            end
`ifdef ETH_FRAME_PADDER_TRUNCATE_EN
            DROP: begin
                axis_in_tready = 1'b1;
                if (axis_in_tvalid && axis_in_tlast) begin
                    w_state_nxt = PASS;
                end
            end
`endif
            default: begin
                w_state_nxt = PASS;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= PASS;
            r_byte_cnt    <= '0;
            r_last_id     <= '0;
            r_last_dest   <= '0;
            r_pad_event   <= 1'b0;
            r_trunc_event <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_pad_event   <= w_pad_evt;
            r_trunc_event <= w_trunc_evt;
            if (r_state == PASS && axis_in_tvalid && w_slot_free) begin
                r_last_id   <= axis_in_tid;
                r_last_dest <= axis_in_tdest;
            end
        end
    end

    axis_out_reg #(
        .PAYLOAD_W(PL_W)
    ) u_out_reg (
        .i_clk    (aclk),
        .i_rst    (areset),
        .i_valid  (w_reg_valid),
        .o_ready  (w_slot_free),
        .i_payload({w_data, w_keep, w_last, w_id, w_dest}),
        .o_valid  (w_out_valid),
        .o_payload(w_out_payload),
        .i_ready  (axis_out_tready)
    );

    assign axis_out_tvalid = w_out_valid;
    assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tid, axis_out_tdest} = w_out_payload;
    assign pad_event   = r_pad_event;
    assign trunc_event = r_trunc_event;

endmodule

// File: tb/tb_eth_frame_padder.sv
// Self-checking bench for eth_frame_padder: directed frames plus randomized traffic
// compared against a byte-stream reference model.
module tb_eth_frame_padder;

    localparam int NB    = 8;
    localparam int MIN_B = 60;
    localparam int MAX_B = 1522;

    logic        aclk;
    logic        areset;
    logic [63:0] in_tdata;
    logic [3:0]  in_tid;
    logic [3:0]  in_tdest;
    logic [7:0]  in_tkeep;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [63:0] out_tdata;
    logic [3:0]  out_tid;
    logic [3:0]  out_tdest;
    logic [7:0]  out_tkeep;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic        pad_event;
    logic        trunc_event;

    eth_frame_padder #(
        .AXIS_BUS_WIDTH   (64),
        .AXIS_ID_WIDTH    (4),
        .AXIS_DEST_WIDTH  (4),
        .MIN_FRAME_BYTES  (MIN_B),
        .MAX_PACKET_LENGTH(MAX_B)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .axis_in_tdata  (in_tdata),
        .axis_in_tid    (in_tid),
        .axis_in_tdest  (in_tdest),
        .axis_in_tkeep  (in_tkeep),
        .axis_in_tlast  (in_tlast),
        .axis_in_tvalid (in_tvalid),
        .axis_in_tready (in_tready),
        .axis_out_tdata (out_tdata),
        .axis_out_tid   (out_tid),
        .axis_out_tdest (out_tdest),
        .axis_out_tkeep (out_tkeep),
        .axis_out_tlast (out_tlast),
        .axis_out_tvalid(out_tvalid),
        .axis_out_tready(out_tready),
        .pad_event      (pad_event),
        .trunc_event    (trunc_event)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
    } beat_t;

    typedef struct {
        beat_t b;
        bit    is_pad;
    } exp_t;

    beat_t in_q[$];
    exp_t  exp_q[$];
    int    exp_pad_ev;
    int    exp_trunc_ev;
    int    total;
    int    bad;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the output is the input byte stream, zero-extended to the
    // minimum length or cut to the maximum, re-chunked into NB-byte beats.
    task automatic add_frame(input int len, input logic [3:0] id, input logic [3:0] dest);
        logic [7:0] fb[$];
        int out_len;
        int in_beats;
        int out_beats;
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        in_beats = (len + NB - 1) / NB;
        for (int k = 0; k < in_beats; k++) begin
            beat_t b;
            b.data = {$urandom, $urandom};
            b.keep = '0;
            for (int j = 0; j < NB; j++) begin
                if (k * NB + j < len) begin
                    b.data[j*8 +: 8] = fb[k*NB + j];
                    b.keep[j] = 1'b1;
                end
            end
            b.last = (k == in_beats - 1);
            b.id   = id;
            b.dest = dest;
            in_q.push_back(b);
        end
        out_len = (len < MIN_B) ? MIN_B : len;
`ifdef ETH_FRAME_PADDER_TRUNCATE_EN
        if (len > MAX_B) begin
            out_len = MAX_B;
            exp_trunc_ev++;
        end
`endif
        if (len < MIN_B) exp_pad_ev++;
        out_beats = (out_len + NB - 1) / NB;
        for (int k = 0; k < out_beats; k++) begin
            exp_t e;
            e.b.data = '0;
            e.b.keep = '0;
            for (int j = 0; j < NB; j++) begin
                if (k * NB + j < out_len) begin
                    e.b.keep[j] = 1'b1;
                    e.b.data[j*8 +: 8] = (k * NB + j < len) ? fb[k*NB + j] : 8'h00;
                end
            end
            e.b.last = (k == out_beats - 1);
            e.b.id   = id;
            e.b.dest = dest;
            e.is_pad = (k >= in_beats);
            exp_q.push_back(e);
        end
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random. rst_at >= 0 pulses reset when
    // that output beat index is on the bus and abandons the rest of the traffic.
    task automatic run(input string tag, input int rdy_mode, input int gap_pct, input int rst_at);
        int          n_rx;
        int          n_pad;
        int          n_trunc;
        int          cyc;
        int          budget;
        int          idx;
        bit          presenting;
        bit          stall_prev;
        logic [127:0] prev_pl;
        logic [127:0] cur_pl;
        logic [63:0]  m;
        exp_t         e;
        n_rx = 0; n_pad = 0; n_trunc = 0; cyc = 0;
        presenting = 1'b0; stall_prev = 1'b0; prev_pl = '0;
        budget = 200 + 8 * (in_q.size() + exp_q.size());
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge aclk);
            if (in_q.size() > 0) begin
                if (!presenting) presenting = ($urandom_range(99) >= gap_pct);
            end else begin
                presenting = 1'b0;
            end
            in_tvalid = presenting;
            if (presenting) begin
                in_tdata = in_q[0].data;
                in_tkeep = in_q[0].keep;
                in_tlast = in_q[0].last;
                in_tid   = in_q[0].id;
                in_tdest = in_q[0].dest;
            end
            case (rdy_mode)
                0:       out_tready = 1'b1;
                1:       out_tready = (cyc % 2 == 0);
                default: out_tready = ($urandom_range(99) < 65);
            endcase
            #1;
            if (pad_event) n_pad++;
            if (trunc_event) n_trunc++;
            cur_pl = 128'({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tid, out_tdest});
            if (stall_prev) check({tag, "_stall_hold"}, cur_pl, prev_pl);
            stall_prev = out_tvalid && !out_tready;
            prev_pl = cur_pl;
            idx = out_tvalid ? 1 : 0;
            if (exp_q.size() > idx && exp_q[idx].is_pad)
                check({tag, "_pad_in_tready"}, 128'(in_tready), 128'(0));
            if (rst_at >= 0 && out_tvalid && n_rx == rst_at) begin
                in_tvalid = 1'b0;
                areset = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                #1;
                check({tag, "_rst_valid"}, 128'(out_tvalid), 128'(0));
                check({tag, "_rst_data"}, 128'(out_tdata), 128'(0));
                check({tag, "_rst_in_tready"}, 128'(in_tready), 128'(1));
                check({tag, "_rst_pad_event"}, 128'(pad_event), 128'(0));
                in_q.delete();
                exp_q.delete();
                exp_pad_ev = 0;
                exp_trunc_ev = 0;
                return;
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_extra_beat", tag), 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    m = '0;
                    for (int j = 0; j < NB; j++) if (e.b.keep[j]) m[j*8 +: 8] = 8'hFF;
                    check($sformatf("%s_b%0d_keep", tag, n_rx), 128'(out_tkeep), 128'(e.b.keep));
                    check($sformatf("%s_b%0d_last", tag, n_rx), 128'(out_tlast), 128'(e.b.last));
                    check($sformatf("%s_b%0d_data", tag, n_rx), 128'(out_tdata & m), 128'(e.b.data & m));
                    check($sformatf("%s_b%0d_iddest", tag, n_rx), 128'({out_tid, out_tdest}),
                          128'({e.b.id, e.b.dest}));
                    if (e.is_pad)
                        check($sformatf("%s_b%0d_padzero", tag, n_rx), 128'(out_tdata), 128'(0));
                end
                n_rx++;
            end
            if (presenting && in_tready) begin
                void'(in_q.pop_front());
                presenting = 1'b0;
            end
            cyc++;
        end
        @(negedge aclk);
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        check({tag, "_timeout"}, 128'(cyc < budget), 128'(1));
        check({tag, "_pad_events"}, 128'(n_pad), 128'(exp_pad_ev));
        check({tag, "_trunc_events"}, 128'(n_trunc), 128'(exp_trunc_ev));
        in_q.delete();
        exp_q.delete();
        exp_pad_ev = 0;
        exp_trunc_ev = 0;
    endtask

    initial begin
        int nf;
        int len;
        total = 0;
        bad = 0;
        exp_pad_ev = 0;
        exp_trunc_ev = 0;
        areset = 1'b1;
        in_tvalid = 1'b0;
        in_tdata = '0;
        in_tkeep = '0;
        in_tlast = 1'b0;
        in_tid = '0;
        in_tdest = '0;
        out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("reset_valid", 128'(out_tvalid), 128'(0));
        check("reset_data", 128'(out_tdata), 128'(0));
        check("reset_keep_last", 128'({out_tkeep, out_tlast}), 128'(0));
        check("reset_id_dest", 128'({out_tid, out_tdest}), 128'(0));
        check("reset_events", 128'({pad_event, trunc_event}), 128'(0));
        check("reset_in_tready", 128'(in_tready), 128'(1));

        add_frame(60, 4'h1, 4'h2);
        run("f60", 0, 0, -1);

        add_frame(14, 4'h3, 4'h4);
        run("f14", 0, 0, -1);

        add_frame(14, 4'h5, 4'h6);
        run("f14_bp", 1, 0, -1);

        add_frame(8, 4'h7, 4'h8);
        add_frame(64, 4'h9, 4'hA);
        run("b2b", 0, 0, -1);

        add_frame(1600, 4'hB, 4'hC);
        run("f1600", 0, 0, -1);

        add_frame(1522, 4'h1, 4'h1);
        add_frame(1523, 4'h2, 4'h2);
        run("f1522_1523", 2, 10, -1);

        add_frame(1, 4'h3, 4'h3);
        add_frame(52, 4'h4, 4'h4);
        add_frame(53, 4'h5, 4'h5);
        add_frame(57, 4'h6, 4'h6);
        add_frame(59, 4'h7, 4'h7);
        add_frame(61, 4'h8, 4'h8);
        run("edges", 2, 20, -1);

        add_frame(14, 4'hD, 4'hE);
        run("rst_pad", 0, 0, 5);

        add_frame(14, 4'hF, 4'h1);
        run("after_rst", 0, 0, -1);

        for (int r = 0; r < 12; r++) begin
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                if ($urandom_range(9) == 0) len = $urandom_range(1500, 1560);
                else len = $urandom_range(1, 140);
                add_frame(len, 4'($urandom), 4'($urandom));
            end
            run($sformatf("rnd%0d", r), 2, $urandom_range(0, 40), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
